// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command receiver: sync byte, command codes
// and the state encodings of the byte receiver and the frame parser.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam logic [7:0] CMD_SET_DELAY = 8'h01;
    localparam logic [7:0] CMD_SET_INTEG = 8'h02;
    localparam logic [7:0] CMD_START     = 8'h03;
    localparam logic [7:0] CMD_STOP      = 8'h04;

    typedef enum logic [2:0] {
        P_HUNT,
        P_CMD,
        P_IDX,
        P_DATA,
        P_CHK
    } parse_state_e;

    // B_BREAK holds off after a low stop bit until the line returns high.
    typedef enum logic [2:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP,
        B_BREAK
    } byte_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop RX synchroniser, mid-bit sampling byte FSM.
// Ports: clk, rst_n (async active-low), rx (raw serial line),
//        byte_valid (1-cycle strobe), byte_data (held until next byte),
//        frame_err (1-cycle strobe, stop bit sampled low).
module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 50000000,
    parameter int unsigned BAUD_RATE     = 230400
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned BIT_CYC  = CLK_FREQUENCY / BAUD_RATE;
    localparam int unsigned HALF_CYC = BIT_CYC / 2;
    localparam int unsigned CNT_W    = $clog2(BIT_CYC);

    logic              rx_meta, rx_s;
    byte_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              byte_valid_d, frame_err_d;

    assign byte_data = shreg_q;

    // Next-state: half-bit into the start bit, then whole bit periods.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            B_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = B_START;
            end
            B_START: begin
                if (cnt_q == CNT_W'(HALF_CYC - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? B_IDLE : B_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            B_DATA: begin
                if (cnt_q == CNT_W'(BIT_CYC - 1)) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    if (bit_q == 3'd7) state_d = B_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            B_STOP: begin
                if (cnt_q == CNT_W'(BIT_CYC - 1)) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_valid_d = 1'b1;
                        state_d      = B_IDLE;
                    end else begin
                        frame_err_d  = 1'b1;
                        state_d      = B_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            B_BREAK: begin
                if (rx_s) state_d = B_IDLE;
            end
            default: state_d = B_IDLE;
        endcase
    end

    // State, synchroniser and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            state_q    <= B_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            byte_valid <= byte_valid_d;
            frame_err  <= frame_err_d;
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// Host command receiver: assembles A5/cmd/index/data[/chk] frames from the
// UART byte stream, validates them and emits one-cycle config strobes.
// UART_CMD_CHECKSUM_EN: when defined, frames carry a trailing XOR checksum.
// Ports: clk, rst_n (async active-low), RX (serial in),
//        cfg_valid/cfg_cmd/cfg_index/cfg_data (accepted command, held),
//        frame_err (bad stop bit), cmd_err (rejected frame), busy (mid-frame).
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 50000000,
    parameter int unsigned BAUD_RATE     = 230400,
    parameter int unsigned RESOLUTION    = 32,
    parameter int unsigned NUM_INPUTS    = 16,
    parameter int unsigned MAX_DELAY     = 250,
    parameter int unsigned TIMEOUT_BITS  = 40,
    localparam int unsigned IW           = $clog2(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX,
    output logic                  cfg_valid,
    output logic [7:0]            cfg_cmd,
    output logic [IW-1:0]         cfg_index,
    output logic [RESOLUTION-1:0] cfg_data,
    output logic                  frame_err,
    output logic                  cmd_err,
    output logic                  busy
);

    localparam int unsigned NB        = RESOLUTION / 8;
    localparam int unsigned DCNT_W    = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned BIT_CYC   = CLK_FREQUENCY / BAUD_RATE;
    localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * BIT_CYC;
    localparam int unsigned TMO_W     = $clog2(TMO_LIMIT + 1);

    logic                  rx_valid, rx_ferr;
    logic [7:0]            rx_data;

    parse_state_e          state_q, state_d;
    logic [DCNT_W-1:0]     dcnt_q, dcnt_d;
    logic [7:0]            cmd_q, cmd_d, idx_q, idx_d;
    logic [RESOLUTION-1:0] data_q, data_d, data_next;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]            chk_q, chk_d;
`endif
    logic                  finish, chk_good;
    logic                  cfg_valid_d, cmd_err_d, busy_d;
    logic [7:0]            cfg_cmd_d;
    logic [IW-1:0]         cfg_index_d;
    logic [RESOLUTION-1:0] cfg_data_d;

    uart_rx_byte #(
        .CLK_FREQUENCY (CLK_FREQUENCY),
        .BAUD_RATE     (BAUD_RATE)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (RX),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .frame_err  (rx_ferr)
    );

    // Payload arrives big-endian: shift in from the bottom.
    assign data_next = RESOLUTION'({data_q, rx_data});

    function automatic logic cmd_ok(input logic [7:0] c, input logic [7:0] i,
                                    input logic [RESOLUTION-1:0] d);
        case (c)
            CMD_SET_DELAY:       cmd_ok = (32'(i) < NUM_INPUTS) && (d <= RESOLUTION'(MAX_DELAY));
            CMD_SET_INTEG:       cmd_ok = (d != '0);
            CMD_START, CMD_STOP: cmd_ok = 1'b1;
            default:             cmd_ok = 1'b0;
        endcase
    endfunction

    // Parser next-state; a byte strobe wins over abort and timeout.
    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        cmd_d       = cmd_q;
        idx_d       = idx_q;
        data_d      = data_q;
        tmo_d       = tmo_q;
`ifdef UART_CMD_CHECKSUM_EN
        chk_d       = chk_q;
`endif
        finish      = 1'b0;
        chk_good    = 1'b1;
        cfg_valid_d = 1'b0;
        cmd_err_d   = 1'b0;
        cfg_cmd_d   = cfg_cmd;
        cfg_index_d = cfg_index;
        cfg_data_d  = cfg_data;

        if (rx_valid) begin
            tmo_d = '0;
            case (state_q)
                P_HUNT: begin
                    if (rx_data == SYNC_BYTE) state_d = P_CMD;
                end
                P_CMD: begin
                    cmd_d   = rx_data;
`ifdef UART_CMD_CHECKSUM_EN
                    chk_d   = rx_data;
`endif
                    state_d = P_IDX;
                end
                P_IDX: begin
                    idx_d   = rx_data;
`ifdef UART_CMD_CHECKSUM_EN
                    chk_d   = chk_q ^ rx_data;
`endif
                    dcnt_d  = '0;
                    state_d = P_DATA;
                end
                P_DATA: begin
                    data_d = data_next;
`ifdef UART_CMD_CHECKSUM_EN
                    chk_d  = chk_q ^ rx_data;
`endif
                    if (dcnt_q == DCNT_W'(NB - 1)) begin
`ifdef UART_CMD_CHECKSUM_EN
                        state_d = P_CHK;
`else
                        state_d = P_HUNT;
                        finish  = 1'b1;
`endif
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end
`ifdef UART_CMD_CHECKSUM_EN
                P_CHK: begin
                    state_d  = P_HUNT;
                    finish   = 1'b1;
                    chk_good = (rx_data == chk_q);
                end
`endif
                default: state_d = P_HUNT;
            endcase
        end else if (rx_ferr || state_q == P_HUNT) begin
            state_d = P_HUNT;
            tmo_d   = '0;
        end else if (tmo_q == TMO_W'(TMO_LIMIT)) begin
            state_d = P_HUNT;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (finish) begin
            if (chk_good && cmd_ok(cmd_d, idx_d, data_d)) begin
                cfg_valid_d = 1'b1;
                cfg_cmd_d   = cmd_d;
                cfg_index_d = IW'(idx_d);
                cfg_data_d  = data_d;
            end else begin
                cmd_err_d   = 1'b1;
            end
        end

        busy_d = (state_d != P_HUNT);
    end

    // Parser state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= P_HUNT;
            dcnt_q    <= '0;
            cmd_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            tmo_q     <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            chk_q     <= '0;
`endif
            cfg_valid <= 1'b0;
            cfg_cmd   <= '0;
            cfg_index <= '0;
            cfg_data  <= '0;
            frame_err <= 1'b0;
            cmd_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            cmd_q     <= cmd_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            tmo_q     <= tmo_d;
`ifdef UART_CMD_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
            cfg_valid <= cfg_valid_d;
            cfg_cmd   <= cfg_cmd_d;
            cfg_index <= cfg_index_d;
            cfg_data  <= cfg_data_d;
            frame_err <= rx_ferr;
            cmd_err   <= cmd_err_d;
            busy      <= busy_d;
        end
    end

endmodule
